vector_exec_unit: RTL and testbench

Multi-cycle, lane-parametrised vector integer execution unit for the RISC-V core's V-extension path. It accepts one vector arithmetic operation per request and sweeps the element range [vstart, vl) of one vector register group over several beats, LANES 32-bit lanes per beat. It honours SEW, vm/mask and tail/prestart-undisturbed policy, and returns the full updated destination register with a done pulse. It sits between the datapath's vector decode (operands from the vector register file) and the register-file write port.

---
 rtl/vector_pkg.sv | 85 ++++++++
 rtl/vector_lane.sv | 44 ++++
 rtl/vector_exec_unit.sv | 163 ++++++++++++++++
 tb/tb_vector_exec_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_pkg : op codes, encodings, FSM states and element helpers         |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package vector_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_MINU = 4'd8;
   localparam logic [3:0] OP_MIN  = 4'd9;
   localparam logic [3:0] OP_MAXU = 4'd10;
   localparam logic [3:0] OP_MAX  = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;

   localparam logic [1:0] SRC_VV  = 2'd0;
   localparam logic [1:0] SRC_VX  = 2'd1;
   localparam logic [1:0] SRC_VI  = 2'd2;
   localparam logic [1:0] SRC_ILL = 2'd3;

   localparam logic [2:0] SEW_8   = 3'd0;
   localparam logic [2:0] SEW_16  = 3'd1;
   localparam logic [2:0] SEW_32  = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [31:0] elems_per_reg(input int vlen, input logic [2:0] sew);
      return 32'(vlen) >> (32'd3 + 32'(sew));
   endfunction

   // Operands arrive zero-extended from the element width; signed views are rebuilt here.
   function automatic logic [31:0] elem_op(input logic [3:0] op, input logic [1:0] sew,
                                           input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [4:0]         sh;
      logic [31:0]        r;
      case (sew)
         2'd0: begin
            sa = {{24{a[7]}}, a[7:0]};
            sb = {{24{b[7]}}, b[7:0]};
            sh = {2'b00, b[2:0]};
         end
         2'd1: begin
            sa = {{16{a[15]}}, a[15:0]};
            sb = {{16{b[15]}}, b[15:0]};
            sh = {1'b0, b[3:0]};
         end
         default: begin
            sa = a;
            sb = b;
            sh = b[4:0];
         end
      endcase
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_SLL:  r = a << sh;
         OP_SRL:  r = a >> sh;
         OP_SRA:  r = 32'(sa >>> sh);
         OP_MINU: r = (a < b) ? a : b;
         OP_MIN:  r = (sa < sb) ? a : b;
         OP_MAXU: r = (a > b) ? a : b;
         OP_MAX:  r = (sa > sb) ? a : b;
         OP_MUL:  r = a * b;
         default: r = a;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vector_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_lane : combinational 32-bit lane, segmented 4x8 / 2x16 / 1x32     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module vector_lane
   import vector_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  sew,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] old,
   input  logic [3:0]  active,
   output logic [31:0] res
);

   logic [31:0] t;

   always_comb begin
      res = old;
      t   = '0;
      case (sew)
         2'd0: begin
            for (int e = 0; e < 4; e++) begin
               t = elem_op(op, sew, {24'b0, a[8*e +: 8]}, {24'b0, b[8*e +: 8]});
               if (active[e]) res[8*e +: 8] = t[7:0];
            end
         end
         2'd1: begin
            for (int e = 0; e < 2; e++) begin
               t = elem_op(op, sew, {16'b0, a[16*e +: 16]}, {16'b0, b[16*e +: 16]});
               if (active[e]) res[16*e +: 16] = t[15:0];
            end
         end
         default: begin
            t = elem_op(op, sew, a, b);
            if (active[0]) res = t;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/vector_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_exec_unit : multi-beat vector integer ALU over [vstart, vl)       |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module vector_exec_unit
   import vector_pkg::*;
#(
   parameter int VLEN  = 128,
   parameter int LANES = 2
) (
   input  logic            SYS_clk,
   input  logic            SYS_reset,
   input  logic            start,
   input  logic [3:0]      op,
   input  logic [1:0]      src_mode,
   input  logic [VLEN-1:0] vs1_data,
   input  logic [VLEN-1:0] vs2_data,
   input  logic [VLEN-1:0] vd_old,
   input  logic [31:0]     scalar,
   input  logic [4:0]      imm5,
   input  logic [2:0]      vsew,
   input  logic [31:0]     vl,
   input  logic [31:0]     vstart,
   input  logic            vm,
   input  logic [VLEN-1:0] mask,
   output logic            busy,
   output logic            done,
   output logic            illegal,
   output logic [VLEN-1:0] result
);

   localparam int NBEATS    = VLEN / (32 * LANES);
   localparam int BW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int LOG_LANES = $clog2(LANES);
   localparam int IW        = $clog2(VLEN);

   state_t          state, state_next;
   logic [BW-1:0]   beat, last_beat;
   logic            finished, ill_r, vm_r;
   logic [3:0]      op_r;
   logic [1:0]      sew_r;
   logic [31:0]     vl_r, vstart_r;
   logic [VLEN-1:0] mask_r, vs2_r, op1_r, res_r;

   logic            accept, req_bad, req_empty;
   logic [31:0]     op1_val, op1_rep;
   logic [VLEN-1:0] op1_vec;
   logic [4:0]      epb_log2;
   logic [BW-1:0]   first_in, last_in;
   logic [LANES-1:0][31:0] lane_out;

   assign accept = (state == ST_IDLE) && start;
   assign result = res_r;

   // Scalar/immediate operands are truncated to SEW and replicated so every lane sees them.
   always_comb begin
      case (src_mode)
         SRC_VX:  op1_val = scalar;
         SRC_VI:  op1_val = (op >= OP_SLL && op <= OP_SRA) ? {27'b0, imm5} : {{27{imm5[4]}}, imm5};
         default: op1_val = '0;
      endcase
      case (vsew)
         SEW_8:   op1_rep = {4{op1_val[7:0]}};
         SEW_16:  op1_rep = {2{op1_val[15:0]}};
         default: op1_rep = op1_val;
      endcase
      op1_vec   = (src_mode == SRC_VV) ? vs1_data : {(VLEN/32){op1_rep}};
      req_bad   = (vsew > SEW_32) || (src_mode == SRC_ILL) || (op > OP_MUL) ||
                  (vl > elems_per_reg(VLEN, vsew));
      req_empty = (vl == 32'd0) || (vstart >= vl);
      epb_log2  = 5'(LOG_LANES + 2) - {3'b000, vsew[1:0]};
      first_in  = BW'(vstart >> epb_log2);
      last_in   = BW'((vl - 32'd1) >> epb_log2);
   end

   always_ff @(posedge SYS_clk or negedge SYS_reset) begin
      if (!SYS_reset) state <= ST_IDLE;
      else            state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_RUN;
         ST_RUN:  if (finished) state_next = ST_DONE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != ST_IDLE);
      done    = (state == ST_DONE);
      illegal = (state == ST_DONE) && ill_r;
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [31:0] word;
      logic [31:0] idx;
      logic [3:0]  act;

      always_comb begin
         word = 32'(beat) * 32'(LANES) + 32'(l);
         idx  = '0;
         act  = '0;
         for (int e = 0; e < 4; e++) begin
            idx    = (word << (2'd2 - sew_r)) + 32'(e);
            act[e] = (32'(e) < (32'd4 >> sew_r)) && (idx >= vstart_r) && (idx < vl_r) &&
                     (vm_r || mask_r[idx[IW-1:0]]);
         end
      end

      vector_lane u_lane (
         .op     (op_r),
         .sew    (sew_r),
         .a      (vs2_r[word*32 +: 32]),
         .b      (op1_r[word*32 +: 32]),
         .old    (res_r[word*32 +: 32]),
         .active (act),
         .res    (lane_out[l])
      );
   end

   // The result register is preloaded with vd_old, so inactive elements stay undisturbed.
   always_ff @(posedge SYS_clk or negedge SYS_reset) begin
      if (!SYS_reset) begin
         beat      <= '0;
         last_beat <= '0;
         finished  <= 1'b0;
         ill_r     <= 1'b0;
         op_r      <= '0;
         sew_r     <= '0;
         vl_r      <= '0;
         vstart_r  <= '0;
         vm_r      <= 1'b0;
         mask_r    <= '0;
         vs2_r     <= '0;
         op1_r     <= '0;
         res_r     <= '0;
      end else if (accept) begin
         beat      <= first_in;
         last_beat <= last_in;
         finished  <= req_bad || req_empty;
         ill_r     <= req_bad;
         op_r      <= op;
         sew_r     <= vsew[1:0];
         vl_r      <= vl;
         vstart_r  <= vstart;
         vm_r      <= vm;
         mask_r    <= mask;
         vs2_r     <= vs2_data;
         op1_r     <= op1_vec;
         res_r     <= vd_old;
      end else if (state == ST_RUN && !finished) begin
         for (int l = 0; l < LANES; l++)
            res_r[(int'(beat) * LANES + l) * 32 +: 32] <= lane_out[l];
         if (beat == last_beat) finished <= 1'b1;
         else                   beat     <= beat + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vector_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vector_exec_unit : directed + randomized bench with element model     |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
module tb_vector_exec_unit;

   localparam int VLEN  = 128;
   localparam int LANES = 2;

   logic            SYS_clk, SYS_reset, start, vm;
   logic [3:0]      op;
   logic [1:0]      src_mode;
   logic [VLEN-1:0] vs1_data, vs2_data, vd_old, mask;
   logic [31:0]     scalar, vl, vstart;
   logic [4:0]      imm5;
   logic [2:0]      vsew;
   logic            busy, done, illegal;
   logic [VLEN-1:0] result;

   int passed = 0;
   int total  = 0;

   vector_exec_unit #(.VLEN(VLEN), .LANES(LANES)) dut (
      .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .start(start), .op(op),
      .src_mode(src_mode), .vs1_data(vs1_data), .vs2_data(vs2_data), .vd_old(vd_old),
      .scalar(scalar), .imm5(imm5), .vsew(vsew), .vl(vl), .vstart(vstart), .vm(vm),
      .mask(mask), .busy(busy), .done(done), .illegal(illegal), .result(result)
   );

   initial SYS_clk = 1'b0;
   always #5 SYS_clk = ~SYS_clk;

   task automatic chk(input string nm, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   // Element-by-element reference over the whole register.
   function automatic void model(input logic [3:0] o, input logic [1:0] sm,
                                 input logic [VLEN-1:0] v1, input logic [VLEN-1:0] v2,
                                 input logic [VLEN-1:0] old, input logic [VLEN-1:0] msk,
                                 input logic [31:0] sc, input logic [4:0] im, input logic [2:0] sw,
                                 input logic [31:0] l, input logic [31:0] vs, input logic vmask,
                                 output logic [VLEN-1:0] res, output bit ill, output int n);
      int sew, nel, epb, sh;
      longint unsigned m, a, b, r;
      longint sa, sb;
      res = old;
      n   = 0;
      ill = (sw > 3'd2) || (sm == 2'd3) || (o > 4'd12);
      if (ill) return;
      sew = 8 << sw;
      nel = VLEN / sew;
      if (l > 32'(nel)) begin
         ill = 1'b1;
         return;
      end
      if (l == 0 || vs >= l) return;
      epb = 32 * LANES / sew;
      n   = (int'(l) + epb - 1) / epb - int'(vs) / epb;
      m   = 64'd1 << sew;
      for (int i = 0; i < nel; i++) begin
         if (!(32'(i) >= vs && 32'(i) < l && (vmask || msk[i]))) continue;
         a = 64'(v2 >> (i * sew)) & (m - 1);
         case (sm)
            2'd0:    b = 64'(v1 >> (i * sew)) & (m - 1);
            2'd1:    b = 64'(sc) & (m - 1);
            default: b = (o >= 4'd5 && o <= 4'd7) ? 64'(im)
                         : ((64'(im) | (im[4] ? ~64'h1F : 64'h0)) & (m - 1));
         endcase
         sa = (a >= m / 2) ? longint'(a) - longint'(m) : longint'(a);
         sb = (b >= m / 2) ? longint'(b) - longint'(m) : longint'(b);
         sh = int'(b % 64'(sew));
         case (o)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << sh;
            4'd6:    r = a >> sh;
            4'd7:    r = $unsigned(sa >>> sh);
            4'd8:    r = (a < b) ? a : b;
            4'd9:    r = (sa < sb) ? a : b;
            4'd10:   r = (a > b) ? a : b;
            4'd11:   r = (sa > sb) ? a : b;
            default: r = a * b;
         endcase
         r   = r & (m - 1);
         res = (res & ~(VLEN'(m - 1) << (i * sew))) | (VLEN'(r) << (i * sew));
      end
   endfunction

   // Cycle-level expectation: accept in idle, N beat cycles plus one, then one done cycle.
   int              mstate, remaining;
   logic [VLEN-1:0] pend, exp_result;
   bit              pend_ill, exp_ill;

   always @(posedge SYS_clk or negedge SYS_reset) begin : model_proc
      logic [VLEN-1:0] r;
      bit              il;
      int              n;
      if (!SYS_reset) begin
         mstate     <= 0;
         remaining  <= 0;
         exp_result <= '0;
         exp_ill    <= 1'b0;
      end else begin
         case (mstate)
            0: if (start) begin
               model(op, src_mode, vs1_data, vs2_data, vd_old, mask, scalar, imm5, vsew,
                     vl, vstart, vm, r, il, n);
               pend      <= r;
               pend_ill  <= il;
               remaining <= n;
               mstate    <= 1;
            end
            1: if (remaining == 0) begin
               mstate     <= 2;
               exp_result <= pend;
               exp_ill    <= pend_ill;
            end else remaining <= remaining - 1;
            default: mstate <= 0;
         endcase
      end
   end

   always @(negedge SYS_clk) begin
      chk("busy", VLEN'(busy), VLEN'(mstate != 0));
      chk("done", VLEN'(done), VLEN'(mstate == 2));
      chk("illegal", VLEN'(illegal), VLEN'(mstate == 2 && exp_ill));
      if (mstate != 1) chk("result", result, exp_result);
   end

   task automatic go(input string nm, input int exp_cyc, input logic [VLEN-1:0] exp_res,
                     input bit exp_ill_lit, input bit poke);
      int cyc;
      bit seen;
      for (int t = 0; t < 20 && busy; t++) begin
         @(posedge SYS_clk);
         #1;
      end
      chk({nm, "_idle"}, VLEN'(busy), '0);
      start = 1'b1;
      @(posedge SYS_clk);
      #1 start = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         if (poke && t == 0) begin
            start = 1'b1;
            op    = 4'd4;
            vs2_data = ~vs2_data;
         end
         @(posedge SYS_clk);
         #1;
         start = 1'b0;
         cyc++;
         if (done) seen = 1'b1;
      end
      chk({nm, "_latency"}, VLEN'(cyc), VLEN'(exp_cyc));
      chk({nm, "_result"}, result, exp_res);
      chk({nm, "_model"}, exp_result, exp_res);
      chk({nm, "_illegal"}, VLEN'(illegal), VLEN'(exp_ill_lit));
   endtask

   task automatic set_req(input logic [3:0] o, input logic [1:0] sm, input logic [2:0] sw,
                          input logic [31:0] l, input logic [31:0] vs, input logic vmask);
      op = o; src_mode = sm; vsew = sw; vl = l; vstart = vs; vm = vmask;
   endtask

   initial begin
      SYS_reset = 1'b0; start = 1'b0;
      set_req(4'd0, 2'd0, 3'd2, 32'd0, 32'd0, 1'b1);
      vs1_data = '0; vs2_data = '0; vd_old = '0; mask = '0; scalar = '0; imm5 = '0;
      repeat (3) @(posedge SYS_clk);
      #1;
      chk("reset_busy", VLEN'(busy), '0);
      chk("reset_done", VLEN'(done), '0);
      chk("reset_result", result, '0);
      SYS_reset = 1'b1;
      @(posedge SYS_clk);
      #1;

      // SEW32 vv add across two beats
      set_req(4'd0, 2'd0, 3'd2, 32'd4, 32'd0, 1'b1);
      vd_old   = 128'h11111111_22222222_33333333_44444444;
      vs2_data = 128'h00000004_00000003_00000002_00000001;
      vs1_data = 128'hFFFFFFFF_0000001E_00000014_0000000A;
      go("add32", 3, 128'h00000003_00000021_00000016_0000000B, 1'b0, 1'b0);

      // Same request with a competing start during RUN
      set_req(4'd0, 2'd0, 3'd2, 32'd4, 32'd0, 1'b1);
      vs2_data = 128'h00000004_00000003_00000002_00000001;
      go("ignore_start", 3, 128'h00000003_00000021_00000016_0000000B, 1'b0, 1'b1);

      set_req(4'd1, 2'd2, 3'd0, 32'd5, 32'd2, 1'b1);
      imm5 = 5'h1F; vd_old = {16{8'hAA}}; vs2_data = {16{8'h7F}};
      go("sub8_vi", 2, 128'hAAAAAAAA_AAAAAAAA_AAAAAA80_8080AAAA, 1'b0, 1'b0);

      set_req(4'd11, 2'd1, 3'd1, 32'd8, 32'd0, 1'b0);
      scalar = 32'hFFFF8000; mask = 128'hF0; vd_old = {8{16'hDEAD}};
      vs2_data = 128'h7FFF_8000_FFFF_0001_1234_8001_0000_9999;
      go("max16_vx", 3, 128'h7FFF_8000_FFFF_0001_DEAD_DEAD_DEAD_DEAD, 1'b0, 1'b0);

      vd_old = 128'h11111111_22222222_33333333_44444444;
      set_req(4'd0, 2'd0, 3'd3, 32'd4, 32'd0, 1'b1);
      go("bad_sew", 1, vd_old, 1'b1, 1'b0);
      set_req(4'd0, 2'd0, 3'd2, 32'd5, 32'd0, 1'b1);
      go("bad_vl", 1, vd_old, 1'b1, 1'b0);
      set_req(4'd0, 2'd0, 3'd2, 32'd0, 32'd0, 1'b1);
      go("vl_zero", 1, vd_old, 1'b0, 1'b0);

      set_req(4'd7, 2'd0, 3'd2, 32'd1, 32'd0, 1'b1);
      vs2_data = {96'h0, 32'h80000000}; vs1_data = {96'h0, 32'd33};
      go("sra32", 2, 128'h11111111_22222222_33333333_C0000000, 1'b0, 1'b0);
      set_req(4'd12, 2'd0, 3'd2, 32'd1, 32'd0, 1'b1);
      vs2_data = {96'h0, 32'h10000}; vs1_data = {96'h0, 32'h10000};
      go("mul32", 2, 128'h11111111_22222222_33333333_00000000, 1'b0, 1'b0);

      // Reset during RUN aborts without a done pulse
      set_req(4'd0, 2'd0, 3'd2, 32'd4, 32'd0, 1'b1);
      start = 1'b1;
      @(posedge SYS_clk);
      #1 start = 1'b0;
      @(posedge SYS_clk);
      #1 SYS_reset = 1'b0;
      #1;
      chk("abort_busy", VLEN'(busy), '0);
      chk("abort_result", result, '0);
      for (int t = 0; t < 3; t++) begin
         @(posedge SYS_clk);
         #1;
         chk("abort_done", VLEN'(done), '0);
      end
      SYS_reset = 1'b1;

      for (int c = 0; c < 1500; c++) begin
         int sw_eff, nel;
         @(negedge SYS_clk);
         start    = ($urandom % 3) == 0;
         op       = (($urandom % 8) == 0) ? 4'(13 + $urandom % 3) : 4'($urandom % 13);
         src_mode = (($urandom % 10) == 0) ? 2'd3 : 2'($urandom % 3);
         vsew     = (($urandom % 10) == 0) ? 3'(3 + $urandom % 5) : 3'($urandom % 3);
         sw_eff   = (vsew > 3'd2) ? 2 : int'(vsew);
         nel      = VLEN / (8 << sw_eff);
         vl       = (($urandom % 10) == 0) ? 32'(nel + 1 + $urandom % 4) : 32'($urandom % (nel + 1));
         vstart   = (($urandom % 4) == 0) ? 32'd0 : 32'($urandom % (vl + 3));
         vm       = 1'($urandom % 2);
         scalar   = $urandom;
         imm5     = 5'($urandom);
         vs1_data = {$urandom, $urandom, $urandom, $urandom};
         vs2_data = {$urandom, $urandom, $urandom, $urandom};
         vd_old   = {$urandom, $urandom, $urandom, $urandom};
         mask     = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge SYS_clk);
      start = 1'b0;
      repeat (10) @(posedge SYS_clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
